pwm_line_loader: RTL and testbench

//  Upstream feeder for the per-channel PWM blocks. Accepts a byte stream (valid/ready) and shifts

---
 rtl/pwm_line_loader_pkg.sv | 23 ++
 rtl/pwm_line_loader_if.sv | 29 ++
 rtl/pwm_line_loader_global_counter.sv | 30 +++
 rtl/pwm_line_loader.sv | 146 ++++++++++++++
 tb/tb_pwm_line_loader.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_line_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_pkg : shared types and constants for the PWM line loader
// Rev 1.0
// ---------------------------------------------------------------------------
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DWIDTH_DEFAULT = 8;
  localparam int STAGE_DEFAULT  = 8;
  localparam int CNT_MAX        = 2**DWIDTH_DEFAULT - 1;

  function automatic int load_cnt_width(input int stage);
    return $clog2(stage + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_line_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_line_loader_if : byte stream in, latched line data / count / hsync out
// Rev 1.0
// ---------------------------------------------------------------------------
interface pwm_line_loader_if #(
  parameter int DWIDTH = 8,
  parameter int STAGE  = 8
) ();
  logic                    start;
  logic [DWIDTH-1:0]       din;
  logic                    din_valid;
  logic                    din_ready;
  logic [STAGE*DWIDTH-1:0] data_q;
  logic [DWIDTH-1:0]       count;
  logic                    hsync;
  logic                    busy;

  modport master (
    output start, din, din_valid,
    input  din_ready, data_q, count, hsync, busy
  );

  modport slave (
    input  start, din, din_valid,
    output din_ready, data_q, count, hsync, busy
  );
endinterface
`default_nettype wire

// File: rtl/pwm_line_loader_global_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_global_counter : shared PWM count with clear/enable and at_max flag
// Rev 1.0
// ---------------------------------------------------------------------------
module pwm_global_counter #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [DWIDTH-1:0] count,
  output logic              at_max
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + DWIDTH'(1);
    end
  end

  assign at_max = (count == {DWIDTH{1'b1}});

endmodule
`default_nettype wire

// File: rtl/pwm_line_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_line_loader : shifts STAGE channel values in, latches a PWM line, runs count/hsync
// Optional macro PWM_PRELOAD_EN: accept the next line during RUN for gapless lines.
// Rev 1.0
// ---------------------------------------------------------------------------
module pwm_line_loader
  import pwm_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int STAGE  = 8
) (
  input  logic               clk,
  input  logic               rst,
  pwm_line_loader_if.slave   bus
);

  localparam int LCW = load_cnt_width(STAGE);
  localparam logic [LCW-1:0] c_last = LCW'(STAGE - 1);
  localparam logic [LCW-1:0] c_full = LCW'(STAGE);
`ifdef PWM_PRELOAD_EN
  localparam logic c_preload = 1'b1;
`else
  localparam logic c_preload = 1'b0;
`endif

  state_t                  r_state;
  state_t                  w_next;
  logic [STAGE*DWIDTH-1:0] r_shreg;
  logic [STAGE*DWIDTH-1:0] w_shift_next;
  logic [STAGE*DWIDTH-1:0] r_data_q;
  logic [LCW-1:0]          r_load_cnt;
  logic                    r_hsync;
  logic                    w_din_ready;
  logic                    w_transfer;
  logic                    w_load_done;
  logic                    w_full;
  logic                    w_latch;
  logic                    w_busy;
  logic                    w_cnt_clear;
  logic                    w_cnt_en;
  logic                    w_at_max;
  logic [DWIDTH-1:0]       w_count;

  // New byte enters at channel STAGE-1; older bytes move toward channel 0.
  generate
    if (STAGE == 1) begin : g_single
      assign w_shift_next = bus.din;
    end else begin : g_chain
      assign w_shift_next = {bus.din, r_shreg[STAGE*DWIDTH-1:DWIDTH]};
    end
  endgenerate

  assign w_din_ready = (r_state == LOAD) ||
                       (c_preload && (r_state == RUN) && (r_load_cnt != c_full));
  assign w_transfer  = bus.din_valid & w_din_ready;
  assign w_load_done = w_transfer && (r_load_cnt == c_last);
  assign w_full      = (r_load_cnt == c_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = LOAD;
      LOAD: if (w_load_done) w_next = RUN;
      RUN: begin
        if (w_at_max) begin
          if (c_preload && (w_full || w_load_done)) begin
            w_next = RUN;
          end else if (c_preload) begin
            w_next = LOAD;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy      = 1'b0;
    w_latch     = 1'b0;
    w_cnt_clear = 1'b1;
    w_cnt_en    = 1'b0;
    case (r_state)
      LOAD: begin
        w_busy  = 1'b1;
        w_latch = w_load_done;
      end
      RUN: begin
        w_busy      = 1'b1;
        w_cnt_clear = w_at_max;
        w_cnt_en    = !w_at_max;
        w_latch     = c_preload && w_at_max && (w_full || w_load_done);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg    <= '0;
      r_data_q   <= '0;
      r_load_cnt <= '0;
      r_hsync    <= 1'b0;
    end else begin
      r_hsync <= w_latch;
      if (w_transfer) begin
        r_shreg <= w_shift_next;
      end
      if (w_latch) begin
        r_data_q   <= w_load_done ? w_shift_next : r_shreg;
        r_load_cnt <= '0;
      end else if (w_transfer) begin
        r_load_cnt <= r_load_cnt + LCW'(1);
      end
    end
  end

  pwm_global_counter #(
    .DWIDTH (DWIDTH)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_cnt_clear),
    .enable (w_cnt_en),
    .count  (w_count),
    .at_max (w_at_max)
  );

  assign bus.din_ready = w_din_ready;
  assign bus.data_q    = r_data_q;
  assign bus.count     = w_count;
  assign bus.hsync     = r_hsync;
  assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_pwm_line_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pwm_line_loader : scoreboard bench for pwm_line_loader (STAGE=8 and STAGE=1)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pwm_line_loader;

`ifdef PWM_PRELOAD_EN
  localparam logic PRELOAD = 1'b1;
`else
  localparam logic PRELOAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_line_loader_if #(.DWIDTH(8), .STAGE(8)) bus0 ();
  pwm_line_loader_if #(.DWIDTH(8), .STAGE(1)) bus1 ();

  pwm_line_loader #(.DWIDTH(8), .STAGE(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pwm_line_loader #(.DWIDTH(8), .STAGE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [63:0] exp_q0[$];
  logic [7:0]  exp_q1[$];
  int          hs_times[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: every hsync must match the next queued line.
  always @(negedge clk) begin
    if (!rst && bus0.hsync) begin
      hs_times.push_back(cyc);
      if (exp_q0.size() == 0) begin
        check("hsync0_unexpected", bus0.hsync, 1'b0);
      end else begin
        logic [63:0] e;
        e = exp_q0.pop_front();
        check("data_q0", bus0.data_q, e);
        check("count0_at_hsync", bus0.count, 0);
      end
    end
    if (!rst && bus1.hsync) begin
      if (exp_q1.size() == 0) begin
        check("hsync1_unexpected", bus1.hsync, 1'b0);
      end else begin
        logic [7:0] e1;
        e1 = exp_q1.pop_front();
        check("data_q1", bus1.data_q, e1);
        check("count1_at_hsync", bus1.count, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic start0();
    bus0.start = 1'b1;
    tick(1);
    bus0.start = 1'b0;
  endtask

  task automatic send0(input logic [7:0] b);
    int w;
    w = 0;
    bus0.din       = b;
    bus0.din_valid = 1'b1;
    while (!bus0.din_ready && w < 1000) begin
      tick(1);
      w++;
    end
    if (w >= 1000) check("send0_timeout", bus0.din_ready, 1'b1);
    tick(1);
    bus0.din_valid = 1'b0;
  endtask

  function automatic logic [63:0] pack8(input logic [7:0] b [8]);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = b[k];
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] line_a [8];
    logic [7:0] line_b [8];
    logic [7:0] line_c [8];
    int pw [8];
    int cnt_err;
    int p0, p1, w;

    bus0.start = 1'b0; bus0.din = '0; bus0.din_valid = 1'b0;
    bus1.start = 1'b0; bus1.din = '0; bus1.din_valid = 1'b0;

    // Reset state
    tick(2);
    check("rst_data_q0", bus0.data_q, 0);
    check("rst_count0", bus0.count, 0);
    check("rst_hsync0", bus0.hsync, 0);
    check("rst_busy0", bus0.busy, 0);
    check("rst_ready0", bus0.din_ready, 0);
    check("rst_busy1", bus1.busy, 0);
    rst = 1'b0;
    tick(2);

    // Line A: bytes 1..8, full line of count checks
    line_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    exp_q0.push_back(pack8(line_a));
    bus0.din_valid = 1'b1;
    bus0.din       = 8'hEE;
    tick(1);
    check("idle_ready0", bus0.din_ready, 0);
    bus0.din_valid = 1'b0;
    start0();
    check("load_busy0", bus0.busy, 1);
    foreach (line_a[i]) send0(line_a[i]);
    check("run_hsync0", bus0.hsync, 1);
    check("run_ch0", bus0.data_q[7:0], 8'd1);
    check("run_ch7", bus0.data_q[63:56], 8'd8);
    cnt_err = 0;
    for (int c = 0; c < 8; c++) pw[c] = 0;
    for (int k = 0; k < 256; k++) begin
      if (bus0.count !== 8'(k)) cnt_err++;
      for (int c = 0; c < 8; c++) if (bus0.count < bus0.data_q[c*8 +: 8]) pw[c]++;
      if (!PRELOAD) begin
        if (k == 5) bus0.din_valid = 1'b1;
        if (k == 10) check("run_ready_no_preload", bus0.din_ready, 0);
        if (k == 20) bus0.start = 1'b1;
        if (k == 21) bus0.start = 1'b0;
      end
      tick(1);
    end
    bus0.din_valid = 1'b0;
    check("count_seq_A", cnt_err, 0);
    for (int c = 0; c < 8; c++) check("pulse_A", pw[c], c + 1);
    check("end_count_A", bus0.count, 0);
    check("end_busy_A", bus0.busy, PRELOAD ? 1 : 0);
    do_reset();

    // Line B: random valid gaps, boundary values 0 and 255
    line_b = '{8'd0, 8'd255, 8'h5A, 8'h01, 8'h80, 8'hFE, 8'h33, 8'h7F};
    exp_q0.push_back(pack8(line_b));
    start0();
    foreach (line_b[i]) begin
      bus0.din_valid = 1'b0;
      tick($urandom_range(0, 3));
      send0(line_b[i]);
    end
    check("hsync_B", bus0.hsync, 1);
    p0 = 0; p1 = 0;
    for (int k = 0; k < 256; k++) begin
      if (bus0.count < bus0.data_q[7:0]) p0++;
      if (bus0.count < bus0.data_q[15:8]) p1++;
      tick(1);
    end
    check("pulse_zero", p0, 0);
    check("pulse_255", p1, 255);
    check("end_busy_B", bus0.busy, PRELOAD ? 1 : 0);
    do_reset();

    // Reset mid-RUN: outputs clear immediately, no hsync afterwards
    exp_q0.push_back(pack8(line_a));
    start0();
    foreach (line_a[i]) send0(line_a[i]);
    tick(50);
    #2 rst = 1'b1;
    #1;
    check("arst_data_q", bus0.data_q, 0);
    check("arst_count", bus0.count, 0);
    check("arst_hsync", bus0.hsync, 0);
    check("arst_busy", bus0.busy, 0);
    check("arst_ready", bus0.din_ready, 0);
    tick(1);
    rst = 1'b0;
    tick(300);

    // Reset mid-LOAD: partial bytes must not appear in the next line
    start0();
    send0(8'hC1); send0(8'hC2); send0(8'hC3);
    do_reset();
    tick(20);
    line_c = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    exp_q0.push_back(pack8(line_c));
    start0();
    foreach (line_c[i]) send0(line_c[i]);
    tick(260);
    do_reset();

    // STAGE=1: a single transfer reaches RUN
    exp_q1.push_back(8'h77);
    bus1.start = 1'b1; tick(1); bus1.start = 1'b0;
    bus1.din = 8'h77; bus1.din_valid = 1'b1;
    tick(1);
    bus1.din_valid = 1'b0;
    check("stage1_hsync", bus1.hsync, 1);
    w = 0;
    while (bus1.count != 8'd255 && w < 400) begin tick(1); w++; end
    check("stage1_reach_max", bus1.count, 8'd255);
    tick(1);
    check("stage1_end_count", bus1.count, 0);
    do_reset();

`ifdef PWM_PRELOAD_EN
    // Three back-to-back lines with no gap
    hs_times.delete();
    exp_q0.push_back(pack8(line_a));
    exp_q0.push_back(pack8(line_b));
    exp_q0.push_back(pack8(line_c));
    start0();
    foreach (line_a[i]) send0(line_a[i]);
    foreach (line_b[i]) send0(line_b[i]);
    foreach (line_c[i]) send0(line_c[i]);
    w = 0;
    while (hs_times.size() < 3 && w < 800) begin tick(1); w++; end
    check("preload_hsync_count", hs_times.size(), 3);
    if (hs_times.size() >= 3) begin
      check("preload_gap1", hs_times[1] - hs_times[0], 256);
      check("preload_gap2", hs_times[2] - hs_times[1], 256);
    end
    tick(260);
    check("preload_to_load", bus0.din_ready, 1);
    do_reset();
`endif

    check("scoreboard0_drained", exp_q0.size(), 0);
    check("scoreboard1_drained", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
